muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the EX stage; owns the architectural HI/LO registers.
- Complements the single-cycle ALU for MULT/MULTU/DIV/DIVU and MTHI/MTLO.
- Decode/EX issues a request with a one-cycle `start` pulse. The unit answers with `busy`, which the hazard logic uses to stall MFHI/MFLO and further requests. A one-cycle `done` pulse marks completion.

Parameters:
- `W`, 32, operand/result width (HI and LO are each W bits).
- `ITER`, 32, number of shift iterations; must equal W.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous active-low reset.
- `start` input 1: request strobe; sampled only in IDLE.
- `op` input 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a` input W: rs operand (multiplicand / dividend).
- `b` input W: rt operand (multiplier / divisor).
- `hi_we` input 1: MTHI write enable.
- `lo_we` input 1: MTLO write enable.
- `wdata` input W: MTHI/MTLO data.
- `busy` output 1: high whenever state != IDLE.
- `done` output 1: one-cycle pulse; HI/LO are updated on the same edge.
- `hi` output W: HI register (product high / remainder).
- `lo` output W: LO register (product low / quotient).

Behaviour:
- Reset (`rst_n`=0 at a rising edge):
  - state=IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0; counter and internal registers cleared.
  - Reset mid-operation aborts with no HI/LO update.
- States: IDLE -> PREP -> RUN -> FIX -> IDLE.
- IDLE:
  - On `start`=1: latch `op`, `a`, `b`; go to PREP.
  - `start` is ignored in any other state.
- PREP (1 cycle):
  - Signed ops: take magnitudes |a|, |b|. Record result sign (a[W-1]^b[W-1]) and remainder sign (a[W-1]).
  - Unsigned ops: operands used as-is.
  - Clear counter; go to RUN.
- RUN (exactly ITER cycles):
  - Multiply: shift-add, one multiplier bit per cycle, into a 2W-bit accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Counter 0..ITER-1; at ITER-1 go to FIX.
- FIX (1 cycle):
  - Apply sign correction: negate product if the result sign is set; negate quotient if the result sign is set; negate remainder if the dividend was negative.
  - Write HI/LO; assert `done` for the following cycle; return to IDLE.
- Latency:
  - Start accepted at edge E0; HI/LO updated at edge E0+ITER+2 (E34 for W=32).
  - `busy`=1 from after E0 through E34; `done`=1 in the cycle following E34; `busy`=0 in that same cycle.
- Results:
  - Multiply: {hi,lo} = full 2W-bit product. Signed and unsigned results are exact; no overflow is possible.
  - Divide: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (two's-complement wrap, no trap).
  - Divide by zero (b=0, either op): lo=all ones, hi=a (original, unsigned view). Latency is the same as a normal divide.
- MTHI/MTLO:
  - Applied on the edge only when state=IDLE; ignored while busy (the pipeline stalls these).
  - `hi_we` and `lo_we` may both be 1 in the same cycle.
  - A write coinciding with an accepted `start` is applied, then overwritten when the operation completes.
- `hi`/`lo` hold their values between writes. They always reflect the last completed operation or MT write, never intermediate state.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=2 -> `busy` rises after E0; `done` after E34; hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=0xFFFFFFFF (-1) b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- DIVU a=100 b=7 -> lo=0x0000000E, hi=0x00000002. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=0x12345678 b=0 -> after 34 cycles lo=0xFFFFFFFF, hi=0x12345678.
- Hazards while busy:
  - Pulse `start` (different operands) and `hi_we`/`lo_we` with wdata=0xDEADBEEF while busy -> both ignored; final result is from the first op only.
  - In IDLE, `hi_we`=1 with wdata=0xDEADBEEF -> hi=0xDEADBEEF next cycle; lo unchanged.
- Drop `rst_n` at cycle 10 of a DIVU -> next edge busy=0, hi=0, lo=0; no `done` pulse. A new start after release completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, with the sign fixed up in a final cycle.
module muldiv_unit #(
  parameter int W    = 32,
  parameter int ITER = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [1:0]      op_reg;
  logic [W-1:0]    a_reg, b_reg, mag_reg;
  logic [2*W-1:0]  acc_reg;
  logic            res_neg_reg, rem_neg_reg, done_reg;
  logic [W-1:0]    hi_reg, lo_reg;

  // op[1] selects divide, op[0] selects the unsigned variant
  logic            is_div, is_signed;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum;
  logic            div_ge;
  logic [W-1:0]    div_sub;
  logic [2*W-1:0]  step_acc;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix, rem_fix;

  assign is_div    = op_reg[1];
  assign is_signed = ~op_reg[0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = PREP;
      PREP: state_next = RUN;
      RUN:  if (cnt_reg == CW'(ITER - 1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    a_mag = (is_signed && a_reg[W-1]) ? -a_reg : a_reg;
    b_mag = (is_signed && b_reg[W-1]) ? -b_reg : b_reg;

    // Multiply: acc = {partial product, remaining multiplier bits}
    mul_sum = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, mag_reg} : '0);

    // Divide: acc = {partial remainder, dividend bits becoming quotient bits}
    div_ge  = acc_reg[2*W-1:W-1] >= {1'b0, mag_reg};
    div_sub = acc_reg[2*W-2:W-1] - mag_reg;

    if (is_div)
      step_acc = div_ge ? {div_sub, acc_reg[W-2:0], 1'b1} : {acc_reg[2*W-2:0], 1'b0};
    else
      step_acc = {mul_sum, acc_reg[W-1:1]};

    prod_fix = res_neg_reg ? -acc_reg : acc_reg;
    quot_fix = res_neg_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0];
    rem_fix  = rem_neg_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      mag_reg     <= '0;
      acc_reg     <= '0;
      res_neg_reg <= 1'b0;
      rem_neg_reg <= 1'b0;
      done_reg    <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      done_reg <= (state_reg == FIX);
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg <= op;
            a_reg  <= a;
            b_reg  <= b;
          end
          if (hi_we) hi_reg <= wdata;
          if (lo_we) lo_reg <= wdata;
        end
        PREP: begin
          cnt_reg     <= '0;
          res_neg_reg <= is_signed & (a_reg[W-1] ^ b_reg[W-1]);
          rem_neg_reg <= is_signed & a_reg[W-1];
          acc_reg     <= is_div ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
          mag_reg     <= is_div ? b_mag : a_mag;
        end
        RUN: begin
          acc_reg <= step_acc;
          cnt_reg <= cnt_reg + CW'(1);
        end
        FIX: begin
          if (is_div) begin
            // Divide by zero reports the untouched dividend rather than a sign-fixed one
            if (b_reg == '0) begin
              hi_reg <= a_reg;
              lo_reg <= '1;
            end else begin
              hi_reg <= rem_fix;
              lo_reg <= quot_fix;
            end
          end else begin
            hi_reg <= prod_fix[2*W-1:W];
            lo_reg <= prod_fix[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
